data_mem_hs: RTL and testbench

- Parametrised successor to the team's byte-addressed data memory.
- Storage is byte-wide and big-endian: the byte at ADDR is the MSB of the word.
- Adds a req/ack handshake with programmable wait states, an out-of-range error response and a post-reset hardware clear sequence.
- Sits in the MEM stage of the pipelined datapath; the stage stalls on busy/ack.

---
 rtl/data_mem_pkg.sv | 31 +++
 rtl/mem_byte_array.sv | 44 ++++
 rtl/data_mem_hs.sv | 164 ++++++++++++++++
 tb/tb_data_mem_hs.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and helpers for the handshaked byte data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic int unsigned nb_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Evaluated one bit wider than any supported address so the last byte never wraps
  function automatic logic in_range(input logic [32:0]  addr,
                                    input logic         byte_acc,
                                    input int unsigned  nb,
                                    input int unsigned  depth);
    logic [32:0] last;
    last = byte_acc ? addr : addr + 33'(nb) - 33'd1;
    return last <= 33'(depth) - 33'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_array
// Description : DEPTH x 8 storage, NB-lane write port, NB-byte async read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_array #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NB     = 2,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic [NB-1:0]     we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NB*8-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NB*8-1:0]   rdata
);

  localparam int unsigned c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_AW1   = ADDR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [c_AW1-1:0] w_widx [NB];
  logic [c_AW1-1:0] w_ridx [NB];

  // Lane i addresses byte base+i and occupies the big-endian slot [NB*8-1-8i -: 8]
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_widx[i] = {1'b0, waddr} + c_AW1'(i);
    assign w_ridx[i] = {1'b0, raddr} + c_AW1'(i);
    assign rdata[NB*8-1-8*i -: 8] = (w_ridx[i] < c_AW1'(DEPTH)) ?
                                    r_mem[w_ridx[i][c_IDX_W-1:0]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i] && (w_widx[i] < c_AW1'(DEPTH))) begin
        r_mem[w_widx[i][c_IDX_W-1:0]] <= wdata[NB*8-1-8*i -: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_hs
// Description : Big-endian byte data memory with req/ack, wait states and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned WAIT_CYC = 1,
  parameter logic [7:0]  CLR_VAL  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              init_done
);

  localparam int unsigned c_NB    = nb_of(DATA_W);
  localparam int unsigned c_PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned c_CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int unsigned c_WLOAD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

  state_t              r_state;
  logic [c_PTR_W-1:0]  r_ptr;
  logic [c_CNT_W-1:0]  r_wcnt;
  logic                r_we;
  logic                r_byte;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;
  logic                r_init_done;

  logic                w_live;
  logic                w_we;
  logic                w_byte;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_go;
  logic                w_in_rng;
  logic [c_NB-1:0]     w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_rd;

  // With no wait states the access completes on the acceptance edge itself,
  // before the capture registers hold anything, so IDLE uses the live inputs.
  always_comb begin
    w_live      = (r_state == S_IDLE);
    w_we        = w_live ? we      : r_we;
    w_byte      = w_live ? byte_en : r_byte;
    w_addr      = w_live ? addr    : r_addr;
    w_wdata     = w_live ? wdata   : r_wdata;
    w_go        = (w_live && req && (WAIT_CYC == 0)) ||
                  ((r_state == S_WAIT) && (r_wcnt == '0));
    w_in_rng    = in_range(33'(w_addr), w_byte, c_NB, DEPTH);
    w_mem_we    = '0;
    w_mem_waddr = w_addr;
    w_mem_wdata = w_wdata;
    if (r_state == S_INIT) begin
      w_mem_we[0]                 = 1'b1;
      w_mem_waddr                 = ADDR_W'(r_ptr);
      w_mem_wdata[DATA_W-1 -: 8]  = CLR_VAL;
    end else if (w_go && w_we && w_in_rng) begin
      if (w_byte) begin
        w_mem_we[0]                = 1'b1;
        w_mem_wdata[DATA_W-1 -: 8] = w_wdata[7:0];
      end else begin
        w_mem_we = '1;
      end
    end
  end

  mem_byte_array #(
    .DEPTH  (DEPTH),
    .NB     (c_NB),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (w_mem_wdata),
    .raddr (w_addr),
    .rdata (w_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_ptr       <= '0;
      r_wcnt      <= '0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_PTR_W'(DEPTH - 1)) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_byte  <= byte_en;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_wcnt  <= c_CNT_W'(c_WLOAD);
            r_state <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wcnt == '0) r_state <= S_RESP;
          else              r_wcnt  <= r_wcnt - 1'b1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_INIT;
      endcase
      if (w_go) begin
        r_ack <= 1'b1;
        r_err <= !w_in_rng;
        if (!w_in_rng) r_rdata <= '0;
        else if (!w_we) r_rdata <= w_byte ? DATA_W'(w_rd[DATA_W-1 -: 8]) : w_rd;
      end
    end
  end

  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign err       = r_err;
  assign busy      = r_busy;
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_hs
// Description : Scoreboard bench for data_mem_hs (16b/1 wait and 32b/0 wait).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req16, we16, be16, req32, we32, be32;
  logic [15:0] addr16, addr32;
  logic [15:0] wdata16;
  logic [31:0] wdata32;
  logic [15:0] rdata16;
  logic [31:0] rdata32;
  logic        ack16, err16, busy16, done16;
  logic        ack32, err32, busy32, done32;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t q16[$];
  exp_t q32[$];
  exp_t m16, m32;

  data_mem_hs #(.DATA_W(16), .DEPTH(64), .ADDR_W(16), .WAIT_CYC(1), .CLR_VAL(8'h00)) u_dut16 (
    .clk(clk), .rst(rst_n), .req(req16), .we(we16), .byte_en(be16), .addr(addr16),
    .wdata(wdata16), .rdata(rdata16), .ack(ack16), .err(err16), .busy(busy16),
    .init_done(done16));

  data_mem_hs #(.DATA_W(32), .DEPTH(64), .ADDR_W(16), .WAIT_CYC(0), .CLR_VAL(8'h00)) u_dut32 (
    .clk(clk), .rst(rst_n), .req(req32), .we(we32), .byte_en(be32), .addr(addr32),
    .wdata(wdata32), .rdata(rdata32), .ack(ack32), .err(err32), .busy(busy32),
    .init_done(done32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ack16) begin
      check("ack16_expected", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) begin
        m16 = q16.pop_front();
        check({m16.tag, "_err"}, 64'(err16), 64'(m16.err));
        if (m16.chk) check({m16.tag, "_rdata"}, 64'(rdata16), 64'(m16.rd));
      end
    end
    if (rst_n && ack32) begin
      check("ack32_expected", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        m32 = q32.pop_front();
        check({m32.tag, "_err"}, 64'(err32), 64'(m32.err));
        if (m32.chk) check({m32.tag, "_rdata"}, 64'(rdata32), 64'(m32.rd));
      end
    end
  end

  task automatic push(input bit s32, input logic [31:0] rd, input bit e, input bit chk,
                      input string tag);
    exp_t x;
    x.rd = rd; x.err = e; x.chk = chk; x.tag = tag;
    if (s32) q32.push_back(x);
    else     q16.push_back(x);
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst16_outputs", {rdata16, ack16, err16, busy16, done16}, {16'h0, 4'b0010});
    check("rst32_outputs", {rdata32, ack32, err32, busy32, done32}, {32'h0, 4'b0010});
    rst_n = 1'b1;
    n = 0;
    while (busy16 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("init16_cycles", 64'(n), 64'd64);
    check("init16_done", 64'(done16), 64'd1);
    check("init32_idle", {busy32, done32}, 64'b01);
  endtask

  // One access; req drops right after acceptance so it cannot re-trigger
  task automatic access(input bit s32, input bit w, input bit b, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err,
                        input string tag);
    int n;
    @(negedge clk);
    if (s32) begin req32 = 1'b1; we32 = w; be32 = b; addr32 = a; wdata32 = d; end
    else     begin req16 = 1'b1; we16 = w; be16 = b; addr16 = a; wdata16 = d[15:0]; end
    @(posedge clk); #1;
    req16 = 1'b0;
    req32 = 1'b0;
    push(s32, exp_rd, exp_err, !w || exp_err, tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s32 ? ack32 : ack16) && n < 20);
    check({tag, "_latency"}, 64'(n), s32 ? 64'd1 : 64'd2);
  endtask

  initial begin
    int n, m;
    req16 = 0; we16 = 0; be16 = 0; addr16 = 0; wdata16 = 0;
    req32 = 0; we32 = 0; be32 = 0; addr32 = 0; wdata32 = 0;
    do_reset();

    access(0, 0, 0, 16'd10, 32'h0,    32'h0000, 0, "rd_w10_cleared");
    access(0, 1, 0, 16'd8,  32'hBEEF, 32'h0,    0, "wr_w8_beef");
    access(0, 0, 1, 16'd8,  32'h0,    32'h00BE, 0, "rd_b8");
    access(0, 0, 1, 16'd9,  32'h0,    32'h00EF, 0, "rd_b9");
    access(0, 0, 0, 16'd8,  32'h0,    32'hBEEF, 0, "rd_w8");
    access(0, 1, 1, 16'd3,  32'hAB42, 32'h0,    0, "wr_b3");
    access(0, 0, 0, 16'd2,  32'h0,    32'h0042, 0, "rd_w2");
    access(0, 0, 0, 16'd3,  32'h0,    32'h4200, 0, "rd_w3_misaligned");
    access(0, 1, 0, 16'd63, 32'h5555, 32'h0000, 1, "wr_w63_oor");
    access(0, 0, 1, 16'd63, 32'h0,    32'h0000, 0, "rd_b63");
    access(0, 0, 0, 16'd62, 32'h0,    32'h0000, 0, "rd_w62_edge");
    access(0, 0, 1, 16'd64, 32'h0,    32'h0000, 1, "rd_b64_oor");

    // Inputs change during WAIT, req held through ack: capture + back-to-back
    @(negedge clk);
    req16 = 1'b1; we16 = 1'b1; be16 = 1'b0; addr16 = 16'd20; wdata16 = 16'h1234;
    @(posedge clk); #1;
    we16 = 1'b0; addr16 = 16'd21; wdata16 = 16'hFFFF;
    push(0, 32'h0, 0, 0, "wr_w20_captured");
    push(0, 32'h3400, 0, 1, "rd_w21_b2b");
    n = 0;
    do begin @(negedge clk); n++; end while (!ack16 && n < 20);
    check("capture_latency", 64'(n), 64'd2);
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 2) req16 = 1'b0;
    end while (!ack16 && m < 20);
    check("b2b_ack_spacing", 64'(m), 64'd3);

    access(1, 1, 0, 16'd4,  32'h12345678, 32'h0,          0, "wr32_w4");
    access(1, 0, 1, 16'd4,  32'h0,        32'h00000012,   0, "rd32_b4");
    access(1, 0, 1, 16'd5,  32'h0,        32'h00000034,   0, "rd32_b5");
    access(1, 0, 1, 16'd6,  32'h0,        32'h00000056,   0, "rd32_b6");
    access(1, 0, 1, 16'd7,  32'h0,        32'h00000078,   0, "rd32_b7");
    access(1, 0, 0, 16'd4,  32'h0,        32'h12345678,   0, "rd32_w4");
    access(1, 0, 0, 16'd61, 32'h0,        32'h00000000,   1, "rd32_w61_oor");

    // Reset in WAIT of a write: no ack, memory fully re-cleared
    access(0, 1, 1, 16'd5, 32'h0077, 32'h0,    0, "wr_b5_77");
    access(0, 0, 1, 16'd5, 32'h0,    32'h0077, 0, "rd_b5_77");
    @(negedge clk);
    req16 = 1'b1; we16 = 1'b1; be16 = 1'b1; addr16 = 16'd5; wdata16 = 16'h0099;
    @(posedge clk); #1;
    req16 = 1'b0;
    do_reset();
    access(0, 0, 1, 16'd5, 32'h0, 32'h0000, 0, "rd_b5_after_abort");
    access(0, 0, 0, 16'd8, 32'h0, 32'h0000, 0, "rd_w8_after_abort");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q16.size() + q32.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
